// File: rtl/hack_cpu_ctrl.sv
// ============================================================================
// hack_cpu_ctrl : multi-cycle Moore controller for the Hack CPU (external ALU)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module hack_cpu_ctrl (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic [15:0] i_Instr,
    input  logic        i_InstrValid,
    output logic        o_InstrReq,
    output logic [14:0] o_PC,
    output logic [5:0]  o_AluCtrl,
    output logic [15:0] o_ALU_X,
    output logic [15:0] o_ALU_Y,
    input  logic [15:0] i_ALU,
    input  logic        i_ZR,
    input  logic        i_NG,
    output logic [14:0] o_AddressM,
    output logic        o_ReadM,
    output logic        o_WriteM,
    output logic [15:0] o_OutM,
    input  logic [15:0] i_InM,
    input  logic        i_MemReady
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEMRD  = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMWR  = 3'd4
    } state_t;

    state_t      state_q;
    logic [14:0] pc_q;
    logic [15:0] a_q;
    logic [15:0] d_q;
    logic [15:0] ir_q;
    logic [15:0] m_q;
    logic [15:0] r_q;
    logic [14:0] waddr_q;
    logic [14:0] jtgt_q;
    logic        take_q;

    logic [14:0] pc_inc_d;
    logic        taken_d;
    logic        unused_ir;

    assign pc_inc_d  = pc_q + 15'd1;
    assign taken_d   = (ir_q[2] & i_NG) | (ir_q[1] & i_ZR) | (ir_q[0] & ~i_ZR & ~i_NG);
    assign unused_ir = &{1'b0, ir_q[14:13]};

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            m_q     <= '0;
            r_q     <= '0;
            waddr_q <= '0;
            jtgt_q  <= '0;
            take_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (i_InstrValid) begin
                        ir_q    <= i_Instr;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!ir_q[15]) begin
                        a_q     <= {1'b0, ir_q[14:0]};
                        pc_q    <= pc_inc_d;
                        state_q <= S_FETCH;
                    end else if (ir_q[12]) begin
                        state_q <= S_MEMRD;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_MEMRD: begin
                    if (i_MemReady) begin
                        m_q     <= i_InM;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Write address and jump target capture A before any A update below
                    r_q     <= i_ALU;
                    waddr_q <= a_q[14:0];
                    jtgt_q  <= a_q[14:0];
                    if (ir_q[4]) d_q <= i_ALU;
                    if (ir_q[5]) a_q <= i_ALU;
                    if (ir_q[3]) begin
                        take_q  <= taken_d;
                        state_q <= S_MEMWR;
                    end else begin
                        pc_q    <= taken_d ? a_q[14:0] : pc_inc_d;
                        state_q <= S_FETCH;
                    end
                end
                S_MEMWR: begin
                    if (i_MemReady) begin
                        pc_q    <= take_q ? jtgt_q : pc_inc_d;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign o_InstrReq = (state_q == S_FETCH);
    assign o_PC       = pc_q;
    assign o_AluCtrl  = (state_q == S_EXEC) ? ir_q[11:6] : 6'd0;
    assign o_ALU_X    = d_q;
    assign o_ALU_Y    = ir_q[12] ? m_q : a_q;
    assign o_AddressM = (state_q == S_MEMWR) ? waddr_q : a_q[14:0];
    assign o_ReadM    = (state_q == S_MEMRD);
    assign o_WriteM   = (state_q == S_MEMWR);
    assign o_OutM     = r_q;

endmodule

`default_nettype wire
